// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and FSM state encoding for the CNN front end.
//   IMG_W, IMG_H : default image geometry in pixels
//   PIX_W        : pixel width in bits
//   ADDR_W       : image_mem pixel address width
//   state_t      : patch address generator FSM states
package cnn_pkg;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LOAD,
        VALID,
        DONE
    } state_t;
endpackage

// File: rtl/window_counter.sv
// window_counter: tracks the 3x3 window position during an image sweep.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : return to the origin (end of sweep)
//   advance   : step to the next window position
//   base      : address of the window's top-left pixel
//   row, col  : output-map coordinates of the window
//   last      : current position is the final window of the sweep
// Address stepping is additive only: base moves by STRIDE along a row and
// row_base moves by STRIDE*IMG_W on each row wrap.
module window_counter #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int STRIDE = 1,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] base,
    output logic [7:0]        row,
    output logic [7:0]        col,
    output logic              last
);
    import cnn_pkg::*;

    localparam int OUT_W = (IMG_W - 3) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - 3) / STRIDE + 1;

    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [7:0]        LAST_COL = 8'(OUT_W - 1);
    localparam logic [7:0]        LAST_ROW = 8'(OUT_H - 1);

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_next;

    assign row_base_next = row_base + ROW_STEP;
    assign last          = (row == LAST_ROW) && (col == LAST_COL);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            base     <= '0;
            row_base <= '0;
            row      <= '0;
            col      <= '0;
        end else if (advance) begin
            if (col == LAST_COL) begin
                // Row wrap: the new row starts at the new row_base.
                row_base <= row_base_next;
                base     <= row_base_next;
                col      <= '0;
                row      <= row + 8'd1;
            end else begin
                base <= base + COL_STEP;
                col  <= col + 8'd1;
            end
        end
    end
endmodule

// File: rtl/patch_addr_gen.sv
// patch_addr_gen: initiator side of the 3x3 patch fetch interface.
// Sweeps a 3x3 window over an IMG_W x IMG_H row-major image, driving nine
// image_mem read addresses, a load strobe one cycle later (read latency 1),
// and then patch_valid until the conv datapath accepts the patch.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : begin a full sweep (only honoured in IDLE)
//   patch_ready                 : downstream accepts the current patch
//   pixel_addr0..pixel_addr8    : window addresses, row-major
//   load                        : capture strobe for the patch latch
//   patch_valid                 : latched patch is valid
//   patch_row, patch_col        : output-map position of the patch
//   busy                        : any state other than IDLE
//   done                        : one-cycle pulse after the last handshake
//   patch_idx (PATCH_IDX_EN)    : linear patch index row*OUT_W+col
// Optional feature macro: PATCH_IDX_EN adds the patch_idx output/counter.
module patch_addr_gen #(
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int STRIDE = 1,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              patch_ready,
    output logic [ADDR_W-1:0] pixel_addr0,
    output logic [ADDR_W-1:0] pixel_addr1,
    output logic [ADDR_W-1:0] pixel_addr2,
    output logic [ADDR_W-1:0] pixel_addr3,
    output logic [ADDR_W-1:0] pixel_addr4,
    output logic [ADDR_W-1:0] pixel_addr5,
    output logic [ADDR_W-1:0] pixel_addr6,
    output logic [ADDR_W-1:0] pixel_addr7,
    output logic [ADDR_W-1:0] pixel_addr8,
    output logic              load,
    output logic              patch_valid,
    output logic [7:0]        patch_row,
    output logic [7:0]        patch_col,
    output logic              busy,
    output logic              done
`ifdef PATCH_IDX_EN
    ,
    output logic [ADDR_W-1:0] patch_idx
`endif
);
    import cnn_pkg::*;

    localparam logic [ADDR_W-1:0] W1 = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W2 = ADDR_W'(2 * IMG_W);

    state_t            state;
    state_t            state_next;
    logic              advance;
    logic              clear;
    logic              last;
    logic              addr_en;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] b;

    window_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .STRIDE (STRIDE),
        .ADDR_W (ADDR_W)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .base    (base),
        .row     (patch_row),
        .col     (patch_col),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE:  if (start) state_next = ISSUE;
            ISSUE: state_next = LOAD;
            LOAD:  state_next = VALID;
            VALID: begin
                if (patch_ready) begin
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        // Window moves at the same edge that re-enters ISSUE.
                        advance    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            DONE: begin
                clear      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign load        = (state == LOAD);
    assign patch_valid = (state == VALID);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // base only changes on a handshake edge, so the constant-offset
    // addresses hold from ISSUE through VALID; they read 0 while idle.
    assign addr_en     = (state != IDLE);
    assign b           = addr_en ? base : '0;
    assign pixel_addr0 = addr_en ? b                 : '0;
    assign pixel_addr1 = addr_en ? b + ADDR_W'(1)    : '0;
    assign pixel_addr2 = addr_en ? b + ADDR_W'(2)    : '0;
    assign pixel_addr3 = addr_en ? b + W1            : '0;
    assign pixel_addr4 = addr_en ? b + W1 + ADDR_W'(1) : '0;
    assign pixel_addr5 = addr_en ? b + W1 + ADDR_W'(2) : '0;
    assign pixel_addr6 = addr_en ? b + W2            : '0;
    assign pixel_addr7 = addr_en ? b + W2 + ADDR_W'(1) : '0;
    assign pixel_addr8 = addr_en ? b + W2 + ADDR_W'(2) : '0;

`ifdef PATCH_IDX_EN
    // Counts non-final handshakes, so it holds OUT_W*OUT_H-1 through DONE.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            patch_idx <= '0;
        end else if (advance) begin
            patch_idx <= patch_idx + ADDR_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_patch_addr_gen.sv
module tb_patch_addr_gen;
    localparam int IW = 28;

    typedef struct {
        int s;
        int n;
        int row;
        int col;
        int a0;
        int a8;
    } vec_t;

    typedef struct {
        int base;
        int row;
        int col;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2, ready1, ready2;
    logic [9:0] a1 [9];
    logic [9:0] a2 [9];
    logic       load1, load2, valid1, valid2, busy1, busy2, done1, done2;
    logic [7:0] row1, row2, col1, col2;
`ifdef PATCH_IDX_EN
    logic [9:0] idx1, idx2;
`endif

    int         which = 1;
    logic [9:0] m_addr [9];
    logic       m_load, m_valid, m_busy, m_done;
    logic [7:0] m_row, m_col;
    int         m_idx;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    vec_t tbl[7];

    always #5 clk = ~clk;

    patch_addr_gen #(.IMG_W(28), .IMG_H(28), .STRIDE(1), .ADDR_W(10)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .patch_ready(ready1),
        .pixel_addr0(a1[0]), .pixel_addr1(a1[1]), .pixel_addr2(a1[2]),
        .pixel_addr3(a1[3]), .pixel_addr4(a1[4]), .pixel_addr5(a1[5]),
        .pixel_addr6(a1[6]), .pixel_addr7(a1[7]), .pixel_addr8(a1[8]),
        .load(load1), .patch_valid(valid1), .patch_row(row1), .patch_col(col1),
        .busy(busy1), .done(done1)
`ifdef PATCH_IDX_EN
        , .patch_idx(idx1)
`endif
    );

    patch_addr_gen #(.IMG_W(28), .IMG_H(28), .STRIDE(2), .ADDR_W(10)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .patch_ready(ready2),
        .pixel_addr0(a2[0]), .pixel_addr1(a2[1]), .pixel_addr2(a2[2]),
        .pixel_addr3(a2[3]), .pixel_addr4(a2[4]), .pixel_addr5(a2[5]),
        .pixel_addr6(a2[6]), .pixel_addr7(a2[7]), .pixel_addr8(a2[8]),
        .load(load2), .patch_valid(valid2), .patch_row(row2), .patch_col(col2),
        .busy(busy2), .done(done2)
`ifdef PATCH_IDX_EN
        , .patch_idx(idx2)
`endif
    );

    always_comb begin
        for (int k = 0; k < 9; k++) m_addr[k] = (which == 2) ? a2[k] : a1[k];
        m_load  = (which == 2) ? load2  : load1;
        m_valid = (which == 2) ? valid2 : valid1;
        m_busy  = (which == 2) ? busy2  : busy1;
        m_done  = (which == 2) ? done2  : done1;
        m_row   = (which == 2) ? row2   : row1;
        m_col   = (which == 2) ? col2   : col1;
`ifdef PATCH_IDX_EN
        m_idx   = (which == 2) ? int'(idx2) : int'(idx1);
`else
        m_idx   = 0;
`endif
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (which == 2) start2 = v; else start1 = v;
    endtask

    task automatic set_ready(input logic v);
        if (which == 2) ready2 = v; else ready1 = v;
    endtask

    function automatic exp_t model(input int n, input int s);
        exp_t e;
        int   ow;
        ow     = (IW - 3) / s + 1;
        e.row  = n / ow;
        e.col  = n % ow;
        e.base = e.row * s * IW + e.col * s;
        return e;
    endfunction

    function automatic int offs_errs();
        int errs = 0;
        for (int k = 0; k < 9; k++)
            if (int'(m_addr[k]) != int'(m_addr[0]) + (k / 3) * IW + (k % 3)) errs++;
        return errs;
    endfunction

    task automatic check_zero_idle(input string tag);
        chk({tag, "_busy"}, int'(m_busy), 0);
        chk({tag, "_valid"}, int'(m_valid), 0);
        chk({tag, "_load"}, int'(m_load), 0);
        chk({tag, "_done"}, int'(m_done), 0);
        chk({tag, "_a0"}, int'(m_addr[0]), 0);
        chk({tag, "_a8"}, int'(m_addr[8]), 0);
        chk({tag, "_row"}, int'(m_row), 0);
        chk({tag, "_col"}, int'(m_col), 0);
`ifdef PATCH_IDX_EN
        chk({tag, "_idx"}, m_idx, 0);
`endif
    endtask

    task automatic sweep(input int w, input int s, input int stall_at, input int abort_at);
        int   ow, np, cycles, load_at, donebad;
        exp_t e;
        which   = w;
        ow      = (IW - 3) / s + 1;
        np      = ow * ow;
        donebad = 0;
        q.delete();
        set_ready(1'b1);
        set_start(1'b1);
        q.push_back(model(0, s));
        for (int n = 0; n < np; n++) begin
            cycles  = 0;
            load_at = -1;
            do begin
                @(negedge clk);
                set_start(1'b0);
                cycles++;
                if (m_load) load_at = cycles;
                if (m_done) donebad++;
            end while (!m_valid && cycles < 8);
            if (!m_valid) begin
                chk("valid_timeout", 0, 1);
                return;
            end
            chk("latency", cycles, 3);
            chk("load_cycle", load_at, 2);
            e = q.pop_front();
            chk("base", int'(m_addr[0]), e.base);
            chk("offsets", offs_errs(), 0);
            chk("row", int'(m_row), e.row);
            chk("col", int'(m_col), e.col);
`ifdef PATCH_IDX_EN
            chk("patch_idx", m_idx, n);
`endif
            foreach (tbl[i]) begin
                if (tbl[i].s == s && tbl[i].n == n) begin
                    chk("vec_row", int'(m_row), tbl[i].row);
                    chk("vec_col", int'(m_col), tbl[i].col);
                    chk("vec_a0", int'(m_addr[0]), tbl[i].a0);
                    chk("vec_a8", int'(m_addr[8]), tbl[i].a8);
                end
            end
            if (n == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero_idle("rst_mid");
                rst = 1'b0;
                set_start(1'b0);
                q.delete();
                return;
            end
            if (n == stall_at) begin
                set_ready(1'b0);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("stall_valid", int'(m_valid), 1);
                    chk("stall_load", int'(m_load), 0);
                    chk("stall_a0", int'(m_addr[0]), e.base);
                    chk("stall_a8", int'(m_addr[8]), e.base + 2 * IW + 2);
                    set_start(i == 3);
                end
                set_start(1'b0);
                set_ready(1'b1);
            end
            if (n < np - 1) q.push_back(model(n + 1, s));
        end
        chk("done_early", donebad, 0);
        @(negedge clk);
        chk("done_pulse", int'(m_done), 1);
        chk("busy_in_done", int'(m_busy), 1);
        chk("addr_hold_done", int'(m_addr[0]), model(np - 1, s).base);
`ifdef PATCH_IDX_EN
        chk("idx_in_done", m_idx, np - 1);
`endif
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check_zero_idle("after_done");
        @(negedge clk);
        chk("start_in_done_ignored", int'(m_busy), 0);
        set_ready(1'b0);
    endtask

    initial begin
        tbl[0] = '{s: 1, n: 0,   row: 0,  col: 0,  a0: 0,   a8: 58};
        tbl[1] = '{s: 1, n: 25,  row: 0,  col: 25, a0: 25,  a8: 83};
        tbl[2] = '{s: 1, n: 26,  row: 1,  col: 0,  a0: 28,  a8: 86};
        tbl[3] = '{s: 1, n: 675, row: 25, col: 25, a0: 725, a8: 783};
        tbl[4] = '{s: 1, n: 319, row: 12, col: 7,  a0: 343, a8: 401};
        tbl[5] = '{s: 2, n: 1,   row: 0,  col: 1,  a0: 2,   a8: 60};
        tbl[6] = '{s: 2, n: 168, row: 12, col: 12, a0: 696, a8: 754};

        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        ready1 = 1'b0;
        ready2 = 1'b0;
        repeat (3) @(negedge clk);
        which = 1;
        check_zero_idle("reset");
        which = 2;
        check_zero_idle("reset2");
        rst = 1'b0;
        @(negedge clk);

        // Full sweep with a 10-cycle stall and an ignored start pulse.
        sweep(1, 1, 5, -1);
        // Reset in the middle of the sweep at patch (12,7).
        sweep(1, 1, -1, 319);
        @(negedge clk);
        // Fresh start after the abort must restart at base 0.
        sweep(1, 1, -1, -1);
        // STRIDE=2 instance.
        sweep(2, 2, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
